rv32i_multicycle_core: RTL and testbench



---
 rtl/rv32i_multicycle_core.sv | 253 +++++++++++++++++++++++++
 tb/tb_rv32i_multicycle_core.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_multicycle_core.sv
// Multi-cycle RV32I/RV32E core: FETCH/DECODE/EXECUTE/[MEM]/WB, 4 cycles per ALU op, 5 per load/store.
// Memory wait states stretch FETCH and MEM with request and address held; traps park in TRAP until reset.
module rv32i_multicycle_core #(
    parameter int                XLEN     = 32,
    parameter int                NUM_REGS = 32,
    parameter logic [XLEN-1:0]   RESET_PC = 32'h0000_0000
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            retire,
    output logic            halt,
    output logic [XLEN-1:0] pc_out
);
    localparam int RW = $clog2(NUM_REGS);
    localparam logic [5:0] NREG = 6'(NUM_REGS);

    localparam logic [2:0] S_FETCH   = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_EXECUTE = 3'd2;
    localparam logic [2:0] S_MEM     = 3'd3;
    localparam logic [2:0] S_WB      = 3'd4;
    localparam logic [2:0] S_TRAP    = 3'd5;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    logic [2:0]      state;
    logic            run;
    logic [XLEN-1:0] pc, ir, rs1_val, rs2_val, imm, result, next_pc;
    logic [XLEN-1:0] regs [NUM_REGS];

    logic [6:0] opcode, funct7;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] funct3;
    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];

    logic            illegal, uses_rs1, uses_rs2, has_rd, bad_reg;
    logic [XLEN-1:0] imm_dec, rf_rs1, rf_rs2;

    always_comb begin
        illegal  = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        has_rd   = 1'b0;
        imm_dec  = '0;
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                has_rd  = 1'b1;
                imm_dec = {ir[31:12], 12'b0};
            end
            OP_JAL: begin
                has_rd  = 1'b1;
                imm_dec = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            end
            OP_JALR: begin
                has_rd   = 1'b1;
                uses_rs1 = 1'b1;
                imm_dec  = {{20{ir[31]}}, ir[31:20]};
                illegal  = (funct3 != 3'b000);
            end
            OP_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                imm_dec  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
                illegal  = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OP_LOAD: begin
                has_rd   = 1'b1;
                uses_rs1 = 1'b1;
                imm_dec  = {{20{ir[31]}}, ir[31:20]};
                illegal  = (funct3 != 3'b010);
            end
            OP_STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                imm_dec  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
                illegal  = (funct3 != 3'b010);
            end
            OP_IMM: begin
                has_rd   = 1'b1;
                uses_rs1 = 1'b1;
                imm_dec  = {{20{ir[31]}}, ir[31:20]};
                if (funct3 == 3'b001)
                    illegal = (funct7 != 7'b0000000);
                else if (funct3 == 3'b101)
                    illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
            end
            OP_REG: begin
                has_rd   = 1'b1;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                illegal  = (funct7 != 7'b0000000) &&
                           !((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            OP_FENCE: illegal = (funct3 != 3'b000);
            // SYSTEM (ECALL/EBREAK, CSRs) and every unknown opcode trap
            default:  illegal = 1'b1;
        endcase
    end

    assign bad_reg = (has_rd   && ({1'b0, rd}  >= NREG)) ||
                     (uses_rs1 && ({1'b0, rs1} >= NREG)) ||
                     (uses_rs2 && ({1'b0, rs2} >= NREG));

    always_comb begin
        rf_rs1 = '0;
        rf_rs2 = '0;
        if (rs1 != 5'd0 && {1'b0, rs1} < NREG) rf_rs1 = regs[rs1[RW-1:0]];
        if (rs2 != 5'd0 && {1'b0, rs2} < NREG) rf_rs2 = regs[rs2[RW-1:0]];
    end

    logic [XLEN-1:0] alu_b, alu_out, ex_result, ex_next_pc, pc_plus4, mem_addr;
    logic            taken, is_mem, is_ctrl;

    assign alu_b    = (opcode == OP_REG) ? rs2_val : imm;
    assign pc_plus4 = pc + 32'd4;
    assign mem_addr = rs1_val + imm;
    assign is_mem   = (opcode == OP_LOAD) || (opcode == OP_STORE);
    assign is_ctrl  = (opcode == OP_JAL) || (opcode == OP_JALR) || (opcode == OP_BRANCH);

    always_comb begin
        case (funct3)
            3'b000:  alu_out = ((opcode == OP_REG) && funct7[5]) ? rs1_val - alu_b : rs1_val + alu_b;
            3'b001:  alu_out = rs1_val << alu_b[4:0];
            3'b010:  alu_out = {{(XLEN-1){1'b0}}, $signed(rs1_val) < $signed(alu_b)};
            3'b011:  alu_out = {{(XLEN-1){1'b0}}, rs1_val < alu_b};
            3'b100:  alu_out = rs1_val ^ alu_b;
            3'b101:  alu_out = funct7[5] ? XLEN'($signed(rs1_val) >>> alu_b[4:0]) : rs1_val >> alu_b[4:0];
            3'b110:  alu_out = rs1_val | alu_b;
            default: alu_out = rs1_val & alu_b;
        endcase
        case (funct3)
            3'b000:  taken = (rs1_val == rs2_val);
            3'b001:  taken = (rs1_val != rs2_val);
            3'b100:  taken = $signed(rs1_val) <  $signed(rs2_val);
            3'b101:  taken = $signed(rs1_val) >= $signed(rs2_val);
            3'b110:  taken = rs1_val <  rs2_val;
            default: taken = rs1_val >= rs2_val;
        endcase
    end

    always_comb begin
        ex_result  = '0;
        ex_next_pc = pc_plus4;
        case (opcode)
            OP_LUI:    ex_result = imm;
            OP_AUIPC:  ex_result = pc + imm;
            OP_JAL: begin
                ex_result  = pc_plus4;
                ex_next_pc = pc + imm;
            end
            OP_JALR: begin
                ex_result  = pc_plus4;
                ex_next_pc = mem_addr & ~32'd1;
            end
            OP_BRANCH: if (taken) ex_next_pc = pc + imm;
            OP_IMM, OP_REG: ex_result = alu_out;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_FETCH;
            run        <= 1'b0;
            pc         <= RESET_PC;
            ir         <= '0;
            rs1_val    <= '0;
            rs2_val    <= '0;
            imm        <= '0;
            result     <= '0;
            next_pc    <= '0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_we    <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            // run holds off the first fetch for one cycle so reset always drops imem_req
            run <= 1'b1;
            case (state)
                S_FETCH: if (run && imem_ready) begin
                    ir    <= imem_rdata;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    rs1_val <= rf_rs1;
                    rs2_val <= rf_rs2;
                    imm     <= imm_dec;
                    state   <= (illegal || bad_reg) ? S_TRAP : S_EXECUTE;
                end
                S_EXECUTE: begin
                    result  <= ex_result;
                    next_pc <= ex_next_pc;
                    if (is_mem) begin
                        if (mem_addr[1:0] != 2'b00) begin
                            state <= S_TRAP;
                        end else begin
                            dmem_addr  <= mem_addr;
                            dmem_wdata <= rs2_val;
                            dmem_we    <= (opcode == OP_STORE);
                            state      <= S_MEM;
                        end
                    end else if (is_ctrl && ex_next_pc[1:0] != 2'b00) begin
                        state <= S_TRAP;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: if (dmem_ready) begin
                    if (!dmem_we) result <= dmem_rdata;
                    state <= S_WB;
                end
                S_WB: begin
                    if (has_rd && rd != 5'd0) regs[rd[RW-1:0]] <= result;
                    pc    <= next_pc;
                    state <= S_FETCH;
                end
                default: state <= S_TRAP;
            endcase
        end
    end

    assign imem_req  = (state == S_FETCH) && run;
    assign imem_addr = pc;
    assign dmem_req  = (state == S_MEM);
    assign retire    = (state == S_WB);
    assign halt      = (state == S_TRAP);
    assign pc_out    = pc;

endmodule

// File: tb/tb_rv32i_multicycle_core.sv
// Directed bench for rv32i_multicycle_core: ALU, branches, jumps, load/store with wait states, traps, resets.
module tb_rv32i_multicycle_core;
    logic        clock, reset;
    logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, retire, halt;
    logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, pc_out;

    logic        reset_e, imem_req_e, dmem_req_e, dmem_we_e, retire_e, halt_e;
    logic [31:0] imem_addr_e, dmem_addr_e, dmem_wdata_e, pc_out_e;

    logic [31:0] imem [0:63];
    logic [31:0] dmem [0:15];
    logic        imem_stall;
    int          dmem_wait, dcnt, n_ret_e;
    int          n_asserts, n_fail;

    rv32i_multicycle_core dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .retire(retire), .halt(halt), .pc_out(pc_out)
    );

    rv32i_multicycle_core #(.NUM_REGS(16)) dut_e (
        .clock(clock), .reset(reset_e),
        .imem_req(imem_req_e), .imem_addr(imem_addr_e), .imem_ready(imem_req_e), .imem_rdata(32'h00100A13),
        .dmem_req(dmem_req_e), .dmem_we(dmem_we_e), .dmem_addr(dmem_addr_e), .dmem_wdata(dmem_wdata_e),
        .dmem_ready(dmem_req_e), .dmem_rdata(32'h0),
        .retire(retire_e), .halt(halt_e), .pc_out(pc_out_e)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign imem_ready = imem_req && !imem_stall;
    assign imem_rdata = imem[imem_addr[7:2]];
    assign dmem_ready = dmem_req && (dcnt >= dmem_wait);
    assign dmem_rdata = dmem[dmem_addr[5:2]];

    always @(posedge clock) begin
        if (dmem_req && !dmem_ready) dcnt <= dcnt + 1;
        else                         dcnt <= 0;
        if (dmem_req && dmem_ready && dmem_we) dmem[dmem_addr[5:2]] <= dmem_wdata;
        if (retire_e) n_ret_e <= n_ret_e + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Counts negedges up to and including the retire pulse; optionally checks the held data request.
    task automatic wait_retire(output int cyc, input bit watch, input logic [31:0] ex_addr,
                               input logic [31:0] ex_wdata, input bit ex_we);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 40) begin
            @(negedge clock);
            cyc++;
            if (watch && dmem_req) begin
                chk("dmem_addr_held", dmem_addr, ex_addr);
                chk("dmem_we_held", {31'b0, dmem_we}, {31'b0, ex_we});
                if (ex_we) chk("dmem_wdata_held", dmem_wdata, ex_wdata);
            end
            seen = retire;
        end
        chk("retire_seen", {31'b0, seen}, 32'd1);
    endtask

    int c;

    initial begin
        n_asserts = 0; n_fail = 0; dcnt = 0; n_ret_e = 0;
        dmem_wait = 0; imem_stall = 1'b0;
        reset = 1'b1; reset_e = 1'b1;
        for (int i = 0; i < 64; i++) imem[i] = 32'h00000013;
        for (int i = 0; i < 16; i++) dmem[i] = 32'h0;
        imem[0]  = 32'h00500093; // addi x1,x0,5
        imem[1]  = 32'hFF908113; // addi x2,x1,-7
        imem[4]  = 32'h00000463; // beq  x0,x0,+8
        imem[6]  = 32'h00001463; // bne  x0,x0,+8
        imem[7]  = 32'hFE5FF0EF; // jal  x1,-0x1c
        imem[8]  = 32'h00202223; // sw   x2,4(x0)
        imem[9]  = 32'h00402183; // lw   x3,4(x0)
        imem[10] = 32'h00900013; // addi x0,x0,9
        imem[11] = 32'h40115213; // srai x4,x2,1
        imem[12] = 32'h002032B3; // sltu x5,x0,x2
        imem[13] = 32'h00202083; // lw   x1,2(x0)

        repeat (3) @(negedge clock);
        chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
        chk("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
        chk("rst_dmem_we", {31'b0, dmem_we}, 32'd0);
        chk("rst_retire", {31'b0, retire}, 32'd0);
        chk("rst_halt", {31'b0, halt}, 32'd0);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_dmem_addr", dmem_addr, 32'h0);
        chk("rst_dmem_wdata", dmem_wdata, 32'h0);
        chk("rst_halt_e", {31'b0, halt_e}, 32'd0);

        reset = 1'b0;
        wait_retire(c, 1'b0, 32'h0, 32'h0, 1'b0);
        wait_retire(c, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("retire_spacing", c, 32'd4);
        @(negedge clock);
        chk("pc_after_addi", pc_out, 32'h8);
        chk("x1_addi", dut.regs[1], 32'd5);
        chk("x2_addi_neg", dut.regs[2], 32'hFFFF_FFFE);

        wait_retire(c, 1'b0, 32'h0, 32'h0, 1'b0);
        wait_retire(c, 1'b0, 32'h0, 32'h0, 1'b0);
        wait_retire(c, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("beq_cycles", c, 32'd4);
        @(negedge clock);
        chk("beq_taken_pc", pc_out, 32'h18);
        wait_retire(c, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clock);
        chk("bne_not_taken_pc", pc_out, 32'h1C);
        wait_retire(c, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("jal_cycles", c, 32'd3);
        imem[2] = 32'h0180006F; // jal x0,+0x18 -> 0x20
        @(negedge clock);
        chk("jal_target_pc", pc_out, 32'h0);
        chk("jal_link_x1", dut.regs[1], 32'h20);

        wait_retire(c, 1'b0, 32'h0, 32'h0, 1'b0);
        wait_retire(c, 1'b0, 32'h0, 32'h0, 1'b0);
        wait_retire(c, 1'b0, 32'h0, 32'h0, 1'b0);
        dmem_wait = 3;
        wait_retire(c, 1'b1, 32'h4, 32'hFFFF_FFFE, 1'b1);
        chk("sw_cycles", c, 32'd8);
        chk("sw_mem_word", dmem[1], 32'hFFFF_FFFE);
        wait_retire(c, 1'b1, 32'h4, 32'h0, 1'b0);
        chk("lw_cycles", c, 32'd8);
        wait_retire(c, 1'b0, 32'h0, 32'h0, 1'b0);
        wait_retire(c, 1'b0, 32'h0, 32'h0, 1'b0);
        wait_retire(c, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clock);
        chk("x0_stays_zero", dut.regs[0], 32'h0);
        chk("x3_load", dut.regs[3], 32'hFFFF_FFFE);
        chk("x4_srai", dut.regs[4], 32'hFFFF_FFFF);
        chk("x5_sltu", dut.regs[5], 32'd1);

        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            chk("misaligned_no_dmem_req", {31'b0, dmem_req}, 32'd0);
        end
        chk("misaligned_halt", {31'b0, halt}, 32'd1);
        chk("trap_no_imem_req", {31'b0, imem_req}, 32'd0);
        chk("trap_pc_held", pc_out, 32'h34);
        chk("trap_x1_unwritten", dut.regs[1], 32'd5);

        imem[0] = 32'h00000073; // ecall
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("reset_clears_halt", {31'b0, halt}, 32'd0);
        chk("reset_pc", pc_out, 32'h0);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        chk("ecall_halt", {31'b0, halt}, 32'd1);

        imem[0] = 32'h0000007F; // reserved opcode
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        chk("bad_opcode_halt", {31'b0, halt}, 32'd1);

        imem[0] = 32'h00000013;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("reset2_halt", {31'b0, halt}, 32'd0);
        chk("reset2_imem_req", {31'b0, imem_req}, 32'd0);
        reset = 1'b0;
        wait_retire(c, 1'b0, 32'h0, 32'h0, 1'b0);
        imem_stall = 1'b1;
        repeat (3) @(negedge clock);
        chk("stalled_fetch_req", {31'b0, imem_req}, 32'd1);
        chk("stalled_fetch_addr", imem_addr, 32'h4);
        reset = 1'b1;
        @(negedge clock);
        chk("reset_drops_imem_req", {31'b0, imem_req}, 32'd0);
        chk("reset_mid_fetch_pc", pc_out, 32'h0);
        reset = 1'b0;
        imem_stall = 1'b0;
        @(negedge clock);
        chk("refetch_req", {31'b0, imem_req}, 32'd1);
        chk("refetch_addr", imem_addr, 32'h0);

        reset_e = 1'b0;
        repeat (8) @(negedge clock);
        chk("rv32e_x20_halt", {31'b0, halt_e}, 32'd1);
        chk("rv32e_no_retire", n_ret_e, 32'd0);
        chk("rv32e_pc_held", pc_out_e, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
